ahb_console_uart: RTL and testbench

AHB_CONSOLE_UART -- requirements
Module: ahb_console_uart

---
 rtl/ahb_console_uart_if.sv | 24 ++
 rtl/ahb_console_uart.sv | 153 +++++++++++++++
 tb/tb_ahb_console_uart.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_console_uart_if.sv
// AHB-Lite slave-side bus bundle for the console UART.
// The interconnect (or bench) drives HREADY; the slave returns HRDATA/HREADYOUT/HRESP.
interface ahb_console_uart_if;
  logic        HSEL;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_console_uart.sv
// AHB-Lite console UART: DATA writes feed an 8-entry TX FIFO serialised as 8N1 on txd.
// Zero-wait-state except a DATA write on a full FIFO, which holds HREADYOUT low until a pop frees space.
module ahb_console_uart #(
  parameter int CLK_DIV   = 16,
  parameter int FIFO_LOG2 = 3
) (
  input  logic              sim_clock,
  input  logic              power_on_reset_n,
  ahb_console_uart_if.slave bus,
  output logic              txd,
  output logic              stop_req
);
  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [1:0]           r_addr;
  logic                 r_write;
  logic                 r_valid;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wr_ptr;
  logic [FIFO_LOG2-1:0] r_rd_ptr;
  logic [FIFO_LOG2:0]   r_count;
  state_t               r_state;
  logic [15:0]          r_div;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_txd;

  logic        w_full;
  logic        w_empty;
  logic        w_data_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_full    = (r_count == (FIFO_LOG2 + 1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_data_wr = r_valid && r_write && (r_addr == 2'd0);
  assign w_push    = w_data_wr && !w_full;
  assign w_bit_end = (r_div == 16'(CLK_DIV - 1));
  // IDLE pops as soon as data is present; STOP pops on its last cycle so frames abut.
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_status  = {24'd0, 4'(r_count), 1'b0, (r_state != S_IDLE), w_empty, w_full};

  assign bus.HRDATA    = (r_valid && !r_write && (r_addr == 2'd1)) ? w_status : 32'd0;
  assign bus.HREADYOUT = !(w_data_wr && w_full);
  assign bus.HRESP     = 1'b0;
  assign txd           = r_txd;
  assign stop_req      = w_push && (bus.HWDATA[7:0] == 8'h0D);
  assign w_unused      = ^{bus.HSIZE, bus.HWDATA[31:8], bus.HADDR[1:0], bus.HTRANS[0]};

  always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 2'd0;
    end else if (bus.HREADY) begin
      r_valid <= bus.HSEL && bus.HTRANS[1];
      r_write <= bus.HWRITE;
      r_addr  <= bus.HADDR[3:2];
    end
  end

  always_ff @(posedge sim_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.HWDATA[7:0];
    end
  end

  always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      r_state <= S_IDLE;
      r_txd   <= 1'b1;
      r_div   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
            r_txd   <= 1'b0;
            r_div   <= 16'd0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_div   <= 16'd0;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
            r_txd   <= r_shift[0];
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_div <= 16'd0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_div <= 16'd0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_console_uart.sv
// Scoreboard bench for ahb_console_uart: stimulus queues expected bytes/read data,
// independent monitors decode txd frames, HRDATA data phases and stop_req pulses.
module tb_ahb_console_uart;
  localparam int CLK_DIV = 16;
  localparam int FRAME   = 10 * CLK_DIV;

  logic sim_clock = 1'b0;
  logic power_on_reset_n = 1'b0;
  logic txd;
  logic stop_req;

  ahb_console_uart_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_console_uart #(.CLK_DIV(CLK_DIV), .FIFO_LOG2(3)) dut (
    .sim_clock        (sim_clock),
    .power_on_reset_n (power_on_reset_n),
    .bus              (bus),
    .txd              (txd),
    .stop_req         (stop_req)
  );

  always #5 sim_clock = ~sim_clock;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [3:0]  addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_frames = 0;
  int          n_stop_seen = 0;
  int          n_cr_written = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  xfer_t       xq[$];
  int          stalls[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HADDR = 4'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0;
  endtask

  task automatic q_xfer(input logic [1:0] trans, input logic wr, input logic [3:0] addr,
                        input logic [31:0] data, input logic [2:0] size);
    xfer_t x;
    x.sel = 1'b1; x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.data = data;
    xq.push_back(x);
  endtask

  task automatic q_write(input logic [3:0] addr, input logic [31:0] data, input logic [2:0] size);
    q_xfer(2'b10, 1'b1, addr, data, size);
    if (addr[3:2] == 2'd0) begin
      exp_tx.push_back(data[7:0]);
      if (data[7:0] == 8'h0D) n_cr_written++;
    end
  endtask

  task automatic q_read(input logic [3:0] addr, input logic [31:0] exp);
    q_xfer(2'b10, 1'b0, addr, 32'd0, 3'd2);
    exp_rd.push_back(exp);
  endtask

  // Pipelined AHB driver: each iteration presents one address phase and the previous data phase.
  task automatic run_bus();
    int n;
    int st;
    n = xq.size();
    stalls.delete();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.HSEL = xq[i].sel; bus.HTRANS = xq[i].trans; bus.HWRITE = xq[i].wr;
        bus.HADDR = xq[i].addr; bus.HSIZE = xq[i].size;
      end else begin
        drive_idle();
      end
      bus.HWDATA = (i > 0) ? xq[i-1].data : 32'd0;
      st = 0;
      @(negedge sim_clock);
      while (!bus.HREADY && st < 1000) begin
        st++;
        @(negedge sim_clock);
      end
      if (st >= 1000) begin
        n_checks++; n_fail++;
        $display("FAIL bus_timeout: HREADY low for %0d cycles, expected release", st);
      end
      @(posedge sim_clock); #1;
      if (i > 0) stalls.push_back(st);
    end
    xq.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sim_clock);
    #1;
  endtask

  // Bus-side monitor: tracks which data phase is live and checks HRDATA / stop_req there.
  logic rd_dp;
  logic wr_dp;
  always @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      rd_dp <= 1'b0;
      wr_dp <= 1'b0;
    end else if (bus.HREADY) begin
      rd_dp <= bus.HSEL && bus.HTRANS[1] && !bus.HWRITE;
      wr_dp <= bus.HSEL && bus.HTRANS[1] && bus.HWRITE && (bus.HADDR[3:2] == 2'd0);
    end
  end

  always @(negedge sim_clock) begin
    if (power_on_reset_n) begin
      if (rd_dp && bus.HREADYOUT) begin
        if (exp_rd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_read: HRDATA 0x%0h with nothing expected", bus.HRDATA);
        end else begin
          check("hrdata", bus.HRDATA, exp_rd.pop_front());
        end
      end
      if ((wr_dp && bus.HREADYOUT && bus.HWDATA[7:0] == 8'h0D) || stop_req)
        check("stop_req", {31'd0, stop_req},
              {31'd0, wr_dp && bus.HREADYOUT && (bus.HWDATA[7:0] == 8'h0D)});
      if (stop_req) n_stop_seen++;
    end
  end

  // Serial monitor: samples every cycle of a frame against the expected 8N1 waveform.
  initial begin : uart_mon
    bit         carry;
    bit         has;
    bit         ab;
    int         bad;
    logic [7:0] eb;
    logic [7:0] got;
    logic [9:0] fr;
    carry = 1'b0;
    forever begin
      if (!carry) @(negedge sim_clock);
      carry = 1'b0;
      if (power_on_reset_n && txd === 1'b0) begin
        has = (exp_tx.size() > 0);
        eb = 8'h00;
        if (has) eb = exp_tx.pop_front();
        fr = {1'b1, eb, 1'b0};
        bad = 0; got = 8'h00; ab = 1'b0;
        for (int s = 0; s < FRAME; s++) begin
          if (s > 0) @(negedge sim_clock);
          if (!power_on_reset_n) begin
            ab = 1'b1;
            break;
          end
          if (txd !== fr[s / CLK_DIV]) bad++;
          if (s >= CLK_DIV && s < 9 * CLK_DIV && (s % CLK_DIV) == CLK_DIV / 2)
            got[s / CLK_DIV - 1] = txd;
        end
        if (!ab) begin
          n_frames++;
          if (!has) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", got);
          end else begin
            check("frame_byte", {24'd0, got}, {24'd0, eb});
            check("frame_bit_timing_errors", bad, 0);
          end
          if (exp_tx.size() > 0) begin
            @(negedge sim_clock);
            check("b2b_no_gap_txd", {31'd0, txd}, 32'd0);
            carry = 1'b1;
          end
        end
      end
    end
  end

  logic [7:0] burst [10] = '{8'h55, 8'hA3, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'hC4, 8'h39, 8'h6B};
  int frames_before;

  initial begin
    drive_idle();
    bus.HWDATA = 32'd0;
    power_on_reset_n = 1'b0;
    repeat (3) @(posedge sim_clock);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_stop_req", {31'd0, stop_req}, 32'd0);
    check("rst_hresp", {31'd0, bus.HRESP}, 32'd0);
    @(negedge sim_clock);
    power_on_reset_n = 1'b1;
    @(posedge sim_clock); #1;

    // Single byte, word-sized write: only HWDATA[7:0]=0x41 is sent.
    q_write(4'h0, 32'hABCD_EF41, 3'd2);
    run_bus();
    wait_cycles(FRAME + 10);
    q_read(4'h4, 32'h0000_0002);
    run_bus();
    check("t1_frames", n_frames, 1);

    // Carriage return raises stop_req and is still transmitted.
    q_write(4'h0, 32'h0000_000D, 3'd0);
    run_bus();
    wait_cycles(FRAME + 10);
    check("t2_stop_pulses", n_stop_seen, 1);
    check("t2_frames", n_frames, 2);

    // Ten back-to-back writes: the 10th stalls until the first STOP bit ends.
    for (int i = 0; i < 10; i++) q_write(4'h0, {24'd0, burst[i]}, 3'd0);
    run_bus();
    for (int i = 0; i < 10; i++) check($sformatf("t3_stall_%0d", i), stalls[i], (i == 9) ? 153 : 0);
    wait_cycles(9 * FRAME + 10);
    check("t3_frames", n_frames, 12);

    // STATUS mid-transmission with three bytes queued, then reserved/DATA reads.
    q_write(4'h0, 32'h31, 3'd0);
    q_write(4'h0, 32'h32, 3'd0);
    q_write(4'h0, 32'h33, 3'd0);
    q_write(4'h0, 32'h34, 3'd0);
    q_read(4'h4, 32'h0000_0034);
    q_read(4'h0, 32'h0000_0000);
    q_read(4'hC, 32'h0000_0000);
    run_bus();
    wait_cycles(4 * FRAME + 20);
    q_read(4'h4, 32'h0000_0002);
    run_bus();
    check("t4_frames", n_frames, 16);

    // Reset during data bit 4 of 0x00 with five bytes still queued.
    q_write(4'h0, 32'h00, 3'd0);
    for (int i = 1; i < 6; i++) q_write(4'h0, 32'h10 + i, 3'd0);
    run_bus();
    frames_before = n_frames;
    wait_cycles(84);
    #2;
    check("t5_txd_before_reset", {31'd0, txd}, 32'd0);
    power_on_reset_n = 1'b0;
    #1;
    check("t5_txd_async_reset", {31'd0, txd}, 32'd1);
    check("t5_hreadyout_in_reset", {31'd0, bus.HREADYOUT}, 32'd1);
    repeat (2) @(posedge sim_clock);
    exp_tx.delete();
    @(negedge sim_clock);
    power_on_reset_n = 1'b1;
    @(posedge sim_clock); #1;
    q_read(4'h4, 32'h0000_0002);
    run_bus();
    wait_cycles(3 * FRAME);
    check("t5_no_frames_after_reset", n_frames, frames_before);

    // Writes to STATUS/reserved offsets and IDLE/BUSY transfers to DATA are ignored.
    q_write(4'h8, 32'h55, 3'd0);
    q_write(4'h4, 32'h0D, 3'd0);
    q_write(4'hC, 32'h77, 3'd0);
    q_xfer(2'b00, 1'b1, 4'h0, 32'h41, 3'd0);
    q_xfer(2'b01, 1'b1, 4'h0, 32'h0D, 3'd0);
    q_read(4'h4, 32'h0000_0002);
    q_read(4'h8, 32'h0000_0000);
    q_read(4'hC, 32'h0000_0000);
    run_bus();
    wait_cycles(2 * FRAME);
    check("t6_no_frames", n_frames, frames_before);

    check("exp_tx_drained", exp_tx.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);
    check("stop_pulse_total", n_stop_seen, n_cr_written);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
